sop_sweep_checker: RTL and testbench
====================================

// Module: sop_sweep_checker
// PURPOSE
//   Sequential stimulus/capture stage around the 4-input SOP function block f(a,b,c,d).
//   - Drives a,b,c,d through minterms 0..15 (a = MSB, d = LSB).
//   - Waits a settle interval for each minterm, then samples f.
//   - Builds the captured 16-bit truth table and compares it against an expected mask.
//   - Gives a self-checking on-chip equivalent of the exhaustive directed sweep.
// PARAMETERS
//   SETTLE_CYCLES  2         cycles abcd is held before f is sampled; legal range 1..15
//   EXPECTED       16'hCC33  expected truth table; bit i = f at minterm i (f = ~(a^c))
// PORTS
//   clk        in   1   single clock; all state updates on the rising edge
//   rst        in   1   synchronous reset, active-high
//   start      in   1   request a sweep; accepted only in IDLE or DONE
//   f          in   1   output of the SOP block under check
//   a,b,c,d    out  1   registered stimulus to the SOP block; {a,b,c,d} = idx
//   busy       out  1   1 while in SETTLE or SAMPLE
//   done       out  1   level; 1 in DONE until the next accepted start or rst
//   pass       out  1   valid when done=1; 1 iff err_count == 0
//   tt         out  16  captured truth table; bit idx is written in the SAMPLE cycle for idx
//   err_count  out  5   number of mismatching minterms, range 0..16
//   fail_idx   out  4   first mismatching minterm (only with SWEEP_FAIL_IDX_EN)
//   fail_vld   out  1   fail_idx holds a captured value (only with SWEEP_FAIL_IDX_EN)
// BEHAVIOUR
//   - Reset values (rst=1 at an edge):
//     - state = IDLE; idx = 0; a = b = c = d = 0.
//     - busy = 0, done = 0, pass = 0, tt = 0, err_count = 0, fail_idx = 0, fail_vld = 0.
//     - rst takes priority over start in every state.
//     - rst mid-sweep abandons the sweep; no partial done is produced.
//   - FSM states: IDLE, SETTLE, SAMPLE, DONE.
//   - IDLE or DONE with start=1:
//     - Clear idx, tt, err_count, fail_vld and the settle counter.
//     - Clear done and pass.
//     - Go to SETTLE.
//   - IDLE with start=0: stay in IDLE. DONE with start=0: stay in DONE, results held.
//   - SETTLE:
//     - {a,b,c,d} = idx; the settle counter increments each cycle.
//     - After SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
//   - SAMPLE (exactly one cycle):
//     - tt[idx] <= f.
//     - If f !== EXPECTED[idx] (X/Z on f counts as a mismatch), err_count <= err_count + 1.
//     - idx == 15: go to DONE; done = 1, pass = (final err_count == 0), idx stays 15.
//     - Otherwise: idx <= idx + 1 (4-bit, never wraps mid-sweep), counter <= 0, go to SETTLE.
//   - start while busy=1 is ignored; no restart and no error flag.
//   - Timing:
//     - Each minterm occupies SETTLE_CYCLES + 1 cycles.
//     - done rises 1 + 16*(SETTLE_CYCLES+1) cycles after the edge that accepts start.
//     - This is 49 cycles with SETTLE_CYCLES = 2.
//   - Width rules:
//     - err_count is 5 bits so that 16 mismatches is representable; it never saturates.
//     - tt bits not yet sampled read 0.
// CONFIGURATION
//   - SWEEP_FAIL_IDX_EN defined:
//     - On the first mismatch of a sweep, fail_idx <= idx and fail_vld <= 1.
//     - Later mismatches do not change fail_idx.
//     - A new accepted start clears fail_vld; fail_idx keeps its last value until overwritten.
//   - SWEEP_FAIL_IDX_EN undefined:
//     - fail_idx and fail_vld ports are absent.
//     - No first-fail register is built; all other behaviour is identical.
// TESTING
//   1. Golden f = ~(a^c), SETTLE_CYCLES = 2, one start pulse:
//      -> done at +49 cycles, tt = 16'hCC33, err_count = 0, pass = 1.
//   2. f stuck at 0:
//      -> tt = 16'h0000, err_count = 8, pass = 0, fail_idx = 0, fail_vld = 1 (if EN).
//   3. f stuck at 1:
//      -> tt = 16'hFFFF, err_count = 8, fail_idx = 2 (if EN).
//   4. f = a^c (fully inverted):
//      -> tt = 16'h33CC, err_count = 16, pass = 0.
//   5. Golden f, start re-pulsed at cycle 10, then rst at cycle 20:
//      -> second start ignored; after rst all outputs equal reset values.
//      -> a fresh start then completes as in scenario 1.
//   6. Golden f, start held high in DONE:
//      -> sweep restarts the next cycle, done drops, and a second done follows 49 cycles later.

Source files
------------

// File: rtl/sop_sweep_checker_if.sv
// sop_sweep_checker_if: bundles the stimulus/capture signals of the SOP sweep checker.
//   start      request a sweep (environment -> checker)
//   f          SOP block output under check (environment -> checker)
//   a,b,c,d    registered stimulus, {a,b,c,d} = current minterm (checker -> environment)
//   busy       sweep in progress
//   done       level, results valid
//   pass       no mismatching minterm in the last sweep
//   tt         captured 16-bit truth table
//   err_count  mismatching minterm count, 0..16
//   fail_idx   first mismatching minterm (SWEEP_FAIL_IDX_EN only)
//   fail_vld   fail_idx holds a captured value (SWEEP_FAIL_IDX_EN only)
// Optional feature macro: SWEEP_FAIL_IDX_EN.
interface sop_sweep_checker_if;
    logic        start;
    logic        f;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] tt;
    logic [4:0]  err_count;
`ifdef SWEEP_FAIL_IDX_EN
    logic [3:0]  fail_idx;
    logic        fail_vld;
    modport master (
        input  start, f,
        output a, b, c, d, busy, done, pass, tt, err_count, fail_idx, fail_vld
    );
    modport slave (
        output start, f,
        input  a, b, c, d, busy, done, pass, tt, err_count, fail_idx, fail_vld
    );
`else
    modport master (
        input  start, f,
        output a, b, c, d, busy, done, pass, tt, err_count
    );
    modport slave (
        output start, f,
        input  a, b, c, d, busy, done, pass, tt, err_count
    );
`endif
endinterface

// File: rtl/sop_sweep_checker.sv
// sop_sweep_checker: sweeps a,b,c,d through minterms 0..15, samples f after a settle
//   interval and compares the captured truth table against EXPECTED.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  sop_sweep_checker_if.master (start, f in; a..d, busy, done, pass, tt,
//        err_count and optionally fail_idx/fail_vld out)
// Optional feature macro: SWEEP_FAIL_IDX_EN (first-fail index capture).
module sop_sweep_checker #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'hCC33
) (
    input logic                 clk,
    input logic                 rst,
    sop_sweep_checker_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] tt_q, tt_d;
    logic [4:0]  err_q, err_d;
    logic        pass_q, pass_d;
    logic        accept;
    logic        mism;
    assign accept = bus.start && (state_q == IDLE || state_q == DONE);
    // Case-equality so an X/Z on f is counted as a mismatch.
    assign mism = !(bus.f === EXPECTED[idx_q]);
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        err_d   = err_q;
        pass_d  = pass_q;
        if (accept) begin
            state_d = SETTLE;
            idx_d   = 4'd0;
            cnt_d   = 4'd0;
            tt_d    = 16'd0;
            err_d   = 5'd0;
            pass_d  = 1'b0;
        end else if (state_q == SETTLE) begin
            cnt_d   = cnt_q + 4'd1;
            state_d = (cnt_q == SETTLE_LAST) ? SAMPLE : SETTLE;
        end else if (state_q == SAMPLE) begin
            tt_d[idx_q] = bus.f;
            err_d       = err_q + 5'(mism);
            if (idx_q == 4'd15) begin
                state_d = DONE;
                pass_d  = (err_d == 5'd0);
            end else begin
                state_d = SETTLE;
                idx_d   = idx_q + 4'd1;
                cnt_d   = 4'd0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            tt_q    <= 16'd0;
            err_q   <= 5'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end
    assign {bus.a, bus.b, bus.c, bus.d} = idx_q;
    assign bus.busy      = (state_q == SETTLE) || (state_q == SAMPLE);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.tt        = tt_q;
    assign bus.err_count = err_q;
`ifdef SWEEP_FAIL_IDX_EN
    logic [3:0] fidx_q, fidx_d;
    logic       fvld_q, fvld_d;
    // fail_idx survives a new start; only fail_vld is cleared.
    always_comb begin
        fidx_d = fidx_q;
        fvld_d = accept ? 1'b0 : fvld_q;
        if (state_q == SAMPLE && mism && !fvld_q) begin
            fidx_d = idx_q;
            fvld_d = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fidx_q <= 4'd0;
            fvld_q <= 1'b0;
        end else begin
            fidx_q <= fidx_d;
            fvld_q <= fvld_d;
        end
    end
    assign bus.fail_idx = fidx_q;
    assign bus.fail_vld = fvld_q;
`endif
endmodule

// File: tb/tb_sop_sweep_checker.sv
// tb_sop_sweep_checker: randomized self-checking bench for sop_sweep_checker.
module tb_sop_sweep_checker;
    localparam int LAT = 1 + 16 * (2 + 1);
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] tbl = 16'd0;
    logic [15:0] ref_exp;
    int          n_chk = 0;
    int          n_pass = 0;
    sop_sweep_checker_if bus ();
    sop_sweep_checker #(.SETTLE_CYCLES(2), .EXPECTED(16'hCC33)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // The SOP block under check is modelled as a lookup table indexed by {a,b,c,d}.
    assign bus.f = tbl[{bus.a, bus.b, bus.c, bus.d}];

    function automatic logic [15:0] golden();
        logic [15:0] t;
        for (int m = 0; m < 16; m++) begin
            logic [3:0] v;
            v    = 4'(m);
            t[m] = ~(v[3] ^ v[1]);
        end
        return t;
    endfunction

    function automatic int ref_err(logic [15:0] t);
        return $countones(t ^ ref_exp);
    endfunction

    function automatic int ref_first(logic [15:0] t);
        logic [15:0] x;
        x = t ^ ref_exp;
        for (int m = 0; m < 16; m++) if (x[m]) return m;
        return -1;
    endfunction

    task automatic do_sweep(output int lat);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if ({bus.a, bus.b, bus.c, bus.d} !== 4'd0) $display("FAIL reset_abcd got %h exp 0", {bus.a, bus.b, bus.c, bus.d}); else n_pass++;
        n_chk++; if ({bus.busy, bus.done, bus.pass} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {bus.busy, bus.done, bus.pass}); else n_pass++;
        n_chk++; if (bus.tt !== 16'd0) $display("FAIL reset_tt got %h exp 0000", bus.tt); else n_pass++;
        n_chk++; if (bus.err_count !== 5'd0) $display("FAIL reset_err got %0d exp 0", bus.err_count); else n_pass++;
`ifdef SWEEP_FAIL_IDX_EN
        n_chk++; if ({bus.fail_idx, bus.fail_vld} !== 5'd0) $display("FAIL reset_fail got %h exp 0", {bus.fail_idx, bus.fail_vld}); else n_pass++;
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_chk++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL idle_hold got done=%b busy=%b exp 0 0", bus.done, bus.busy); else n_pass++;
    endtask

    task automatic test_patterns();
        logic [15:0] pats [$];
        int          lat;
        pats = '{golden(), 16'h0000, 16'hFFFF, ~golden()};
        repeat (6) pats.push_back(16'($urandom));
        foreach (pats[i]) begin
            tbl = pats[i];
            do_sweep(lat);
            n_chk++; if (lat != LAT) $display("FAIL pat%0d_latency got %0d exp %0d", i, lat, LAT); else n_pass++;
            n_chk++; if (bus.tt !== tbl) $display("FAIL pat%0d_tt got %h exp %h", i, bus.tt, tbl); else n_pass++;
            n_chk++; if (int'(bus.err_count) != ref_err(tbl)) $display("FAIL pat%0d_err got %0d exp %0d", i, bus.err_count, ref_err(tbl)); else n_pass++;
            n_chk++; if (bus.pass !== (ref_err(tbl) == 0)) $display("FAIL pat%0d_pass got %b exp %b", i, bus.pass, ref_err(tbl) == 0); else n_pass++;
            n_chk++; if (bus.busy !== 1'b0) $display("FAIL pat%0d_busy got %b exp 0", i, bus.busy); else n_pass++;
`ifdef SWEEP_FAIL_IDX_EN
            n_chk++; if (bus.fail_vld !== (ref_first(tbl) >= 0)) $display("FAIL pat%0d_fail_vld got %b exp %b", i, bus.fail_vld, ref_first(tbl) >= 0); else n_pass++;
            if (ref_first(tbl) >= 0) begin
                n_chk++; if (int'(bus.fail_idx) != ref_first(tbl)) $display("FAIL pat%0d_fail_idx got %0d exp %0d", i, bus.fail_idx, ref_first(tbl)); else n_pass++;
            end
`endif
            @(posedge clk);
            #1;
            n_chk++; if (bus.done !== 1'b1 || bus.tt !== tbl) $display("FAIL pat%0d_hold got done=%b tt=%h exp 1 %h", i, bus.done, bus.tt, tbl); else n_pass++;
        end
    endtask

    task automatic test_progress();
        int          k;
        int          lat;
        logic [15:0] mask;
        for (int r = 0; r < 4; r++) begin
            tbl = 16'($urandom);
            k = $urandom_range(15, 0);
            mask = 16'((32'd1 << k) - 1);
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            repeat (3 * k) @(posedge clk);
            #1;
            n_chk++; if (bus.tt !== (tbl & mask)) $display("FAIL progress_tt k=%0d got %h exp %h", k, bus.tt, tbl & mask); else n_pass++;
            n_chk++; if (int'({bus.a, bus.b, bus.c, bus.d}) != k) $display("FAIL progress_abcd got %0d exp %0d", {bus.a, bus.b, bus.c, bus.d}, k); else n_pass++;
            n_chk++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL progress_busy got busy=%b done=%b exp 1 0", bus.busy, bus.done); else n_pass++;
            lat = 0;
            while (!bus.done && lat < 200) begin
                @(posedge clk);
                #1;
                lat++;
            end
            n_chk++; if (bus.done !== 1'b1 || bus.tt !== tbl) $display("FAIL progress_end got done=%b tt=%h exp 1 %h", bus.done, bus.tt, tbl); else n_pass++;
        end
    endtask

    task automatic test_ignore_and_rst();
        int lat;
        tbl = golden();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        while (lat < 20) begin
            bus.start = (lat == 10);
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        n_chk++; if ({bus.a, bus.b, bus.c, bus.d} !== 4'd6) $display("FAIL ignore_idx got %0d exp 6", {bus.a, bus.b, bus.c, bus.d}); else n_pass++;
        n_chk++; if (bus.tt !== (golden() & 16'h003F)) $display("FAIL ignore_tt got %h exp %h", bus.tt, golden() & 16'h003F); else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_chk++; if ({bus.a, bus.b, bus.c, bus.d, bus.busy, bus.done, bus.pass} !== 7'd0) $display("FAIL midrst_state got %b exp 0", {bus.a, bus.b, bus.c, bus.d, bus.busy, bus.done, bus.pass}); else n_pass++;
        n_chk++; if (bus.tt !== 16'd0 || bus.err_count !== 5'd0) $display("FAIL midrst_tt got tt=%h err=%0d exp 0 0", bus.tt, bus.err_count); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL midrst_no_done got done=%b busy=%b exp 0 0", bus.done, bus.busy); else n_pass++;
        do_sweep(lat);
        n_chk++; if (lat != LAT) $display("FAIL fresh_latency got %0d exp %0d", lat, LAT); else n_pass++;
        n_chk++; if (bus.tt !== golden() || bus.pass !== 1'b1) $display("FAIL fresh_result got tt=%h pass=%b exp %h 1", bus.tt, bus.pass, golden()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        tbl = ~golden();
        do_sweep(lat);
        tbl = golden();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        n_chk++; if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.pass !== 1'b0) $display("FAIL b2b_restart got done=%b busy=%b pass=%b exp 0 1 0", bus.done, bus.busy, bus.pass); else n_pass++;
        n_chk++; if (bus.tt !== 16'd0 || bus.err_count !== 5'd0) $display("FAIL b2b_clear got tt=%h err=%0d exp 0 0", bus.tt, bus.err_count); else n_pass++;
        lat = 1;
        while (!bus.done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        n_chk++; if (lat != LAT) $display("FAIL b2b_latency got %0d exp %0d", lat, LAT); else n_pass++;
        n_chk++; if (bus.tt !== golden() || bus.err_count !== 5'd0 || bus.pass !== 1'b1) $display("FAIL b2b_result got tt=%h err=%0d pass=%b exp %h 0 1", bus.tt, bus.err_count, bus.pass, golden()); else n_pass++;
        @(posedge clk);
        #1;
        n_chk++; if (bus.done !== 1'b1) $display("FAIL b2b_hold got done=%b exp 1", bus.done); else n_pass++;
    endtask

    initial begin
        bus.start = 1'b0;
        ref_exp = golden();
        test_reset();
        test_patterns();
        test_progress();
        test_ignore_and_rst();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
